// File: rtl/mem_req_arbiter_pkg.sv
// Shared types, AXI constants and write-strobe helper for mem_req_arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} arb_state_e;

  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_BURST_INC = 2'b01;
  localparam logic [3:0] AXI_LEN_ONE   = 4'd0;

  // Cache access type codes, same encoding as the cache-side definitions.
  localparam logic [2:0] CACHE_BYTE  = 3'b000;
  localparam logic [2:0] CACHE_HWORD = 3'b001;
  localparam logic [2:0] CACHE_WORD  = 3'b010;

  function automatic logic [3:0] strb_gen(input logic [2:0] req_type, input logic [1:0] addr_lo);
    case (req_type)
      CACHE_BYTE:  strb_gen = 4'b0001 << addr_lo;
      CACHE_HWORD: strb_gen = 4'b0011 << {addr_lo[1], 1'b0};
      default:     strb_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter_arb2.sv
// Two-input grant selection for mem_req_arbiter.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise r1 always wins.
module arb2 (
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       upd_grant,
`endif
  input  logic [1:0] req,
  output logic       win
);

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant <= 1'b1;
    else if (upd)
      last_grant <= upd_grant;
  end

  assign win = (req == 2'b11) ? ~last_grant : req[1];
`else
  assign win = req[1];
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one single-beat AXI master between the instruction (r0) and data (r1) cache miss ports.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration instead of fixed r1 priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_in,
  input  logic [2:0]        r0_type,
  output logic [DATA_W-1:0] r0_out,
  output logic              r0_wait,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_in,
  input  logic [2:0]        r1_type,
  output logic [DATA_W-1:0] r1_out,
  output logic              r1_wait,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              err
);

  arb_state_e        state;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  logic              win;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_type;
  logic              done;
  logic              unused_axi;

`ifdef MEM_ARB_RR_EN
  arb2 u_arb2 (
    .clk       (clk),
    .rst       (rst),
    .upd       (done),
    .upd_grant (grant),
    .req       ({r1_req, r0_req}),
    .win       (win)
  );
`else
  arb2 u_arb2 (
    .req (({r1_req, r0_req})),
    .win (win)
  );
`endif

  assign sel_write = win ? r1_write : r0_write;
  assign sel_addr  = win ? r1_addr  : r0_addr;
  assign sel_type  = win ? r1_type  : r0_type;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req | r1_req) begin
            grant   <= win;
            addr_q  <= sel_addr;
            wdata_q <= win ? r1_in : r0_in;
            wstrb_q <= sel_write ? strb_gen(sel_type, sel_addr[1:0]) : 4'b0000;
            if (sel_write) begin
              state     <= AW;
              awvalid_q <= 1'b1;
            end else begin
              state     <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= R;
        end
        R: if (RVALID) begin
          rready_q <= 1'b0;
          state    <= IDLE;
        end
        AW: if (AWREADY) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          state     <= W;
        end
        W: if (WREADY) begin
          wvalid_q <= 1'b0;
          bready_q <= 1'b1;
          state    <= B;
        end
        B: if (BVALID) begin
          bready_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response IDs are not checked: the response always belongs to the current grant.
  assign done = (rready_q & RVALID) | (bready_q & BVALID);
  assign err  = (rready_q & RVALID & RRESP[1]) | (bready_q & BVALID & BRESP[1]);

  assign r0_wait = r0_req & ~(~grant & done);
  assign r1_wait = r1_req & ~(grant & done);
  assign r0_out  = (~grant & done) ? RDATA : '0;
  assign r1_out  = (grant & done) ? RDATA : '0;

  assign ARID    = ID_W'(grant);
  assign ARADDR  = addr_q;
  assign ARLEN   = AXI_LEN_ONE;
  assign ARSIZE  = AXI_SIZE_WORD;
  assign ARBURST = AXI_BURST_INC;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = ID_W'(grant);
  assign AWADDR  = addr_q;
  assign AWLEN   = AXI_LEN_ONE;
  assign AWSIZE  = AXI_SIZE_WORD;
  assign AWBURST = AXI_BURST_INC;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = wvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

  assign unused_axi = ^{RID, BID, RLAST, RRESP[0], BRESP[0]};

endmodule
